laser_eval_ctrl: RTL and testbench

// - Coverage-evaluation controller for the LASER solver: stores one set of NPTS target points, then

---
 rtl/laser_eval_ctrl.sv | 149 ++++++++++++++
 tb/tb_laser_eval_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/laser_eval_ctrl.sv
// laser_eval_ctrl: LASER coverage evaluator, one stored point per cycle through a shared distance engine.
// Define LASER_BEST_TRACK_EN to build best-result tracking; otherwise BEST_* outputs are constants.
module laser_eval_ctrl #(
  parameter int NPTS = 40,
  parameter int CW = 4,
  parameter int R2 = 16,
  localparam int NW = $clog2(NPTS + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LD_START,
  input  logic          LD_VALID,
  input  logic [CW-1:0] LD_X,
  input  logic [CW-1:0] LD_Y,
  output logic          LOADED,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [CW-1:0] REQ_C1X,
  input  logic [CW-1:0] REQ_C1Y,
  input  logic [CW-1:0] REQ_C2X,
  input  logic [CW-1:0] REQ_C2Y,
  output logic          RES_VALID,
  input  logic          RES_READY,
  output logic [NW-1:0] RES_CNT,
  output logic [NW-1:0] BEST_CNT,
  output logic [CW-1:0] BEST_C1X,
  output logic [CW-1:0] BEST_C1Y,
  output logic [CW-1:0] BEST_C2X,
  output logic [CW-1:0] BEST_C2Y
);
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  localparam logic [NW-1:0] NPTS_V = NW'(NPTS);
  localparam logic [NW-1:0] LAST_V = NW'(NPTS - 1);
  localparam logic [2*CW:0] R2_V = (2*CW+1)'(R2);
  localparam logic [CW-1:0] SEVEN = CW'(7);
  state_t state, state_n;
  logic [CW-1:0] mem_x [NPTS];
  logic [CW-1:0] mem_y [NPTS];
  logic [NW-1:0] ld_ptr, idx, acc, res_cnt, fin_cnt;
  logic [CW-1:0] c1x, c1y, c2x, c2y, px, py;
  logic loaded, hit, hit_q, accept, fin, ld_we;

  function automatic logic covers(input logic [CW-1:0] cx, cy, x, y);
    logic [CW-1:0] dx, dy;
    logic [2*CW-1:0] sx, sy;
    dx = cx > x ? cx - x : x - cx;
    dy = cy > y ? cy - y : y - cy;
    sx = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    sy = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    return ({1'b0, sx} + {1'b0, sy}) <= R2_V;
  endfunction

  // hit is registered, so the final point lands one edge after idx reaches NPTS
  always_comb begin
    REQ_READY = state == IDLE && loaded;
    RES_VALID = state == RESP;
    accept = REQ_VALID && REQ_READY;
    fin = state == EVAL && idx == NPTS_V;
    ld_we = state == IDLE && !LD_START && LD_VALID && !loaded;
    px = idx < NPTS_V ? mem_x[idx] : '0;
    py = idx < NPTS_V ? mem_y[idx] : '0;
    hit = covers(c1x, c1y, px, py) | covers(c2x, c2y, px, py);
    fin_cnt = acc + NW'(hit_q);
    state_n = state;
    if (state == IDLE && accept) state_n = EVAL;
    if (fin) state_n = RESP;
    if (state == RESP && RES_READY) state_n = IDLE;
  end

  always_ff @(posedge CLK) state <= !RST ? IDLE : state_n;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ld_ptr <= '0;
      loaded <= 1'b0;
      idx <= '0;
      acc <= '0;
      hit_q <= 1'b0;
      res_cnt <= '0;
      c1x <= '0;
      c1y <= '0;
      c2x <= '0;
      c2y <= '0;
    end else begin
      if (state == IDLE && LD_START) begin
        ld_ptr <= '0;
        loaded <= 1'b0;
      end else if (ld_we) begin
        ld_ptr <= ld_ptr + 1'b1;
        loaded <= ld_ptr == LAST_V;
      end
      if (accept) begin
        c1x <= REQ_C1X;
        c1y <= REQ_C1Y;
        c2x <= REQ_C2X;
        c2y <= REQ_C2Y;
        idx <= '0;
        acc <= '0;
        hit_q <= 1'b0;
      end else if (state == EVAL && !fin) begin
        idx <= idx + 1'b1;
        acc <= fin_cnt;
        hit_q <= hit;
      end
      if (fin) res_cnt <= fin_cnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && ld_we) begin
      mem_x[ld_ptr] <= LD_X;
      mem_y[ld_ptr] <= LD_Y;
    end
  end

  assign LOADED = loaded;
  assign RES_CNT = res_cnt;

`ifdef LASER_BEST_TRACK_EN
  logic [NW-1:0] best_cnt;
  logic [CW-1:0] b1x, b1y, b2x, b2y;
  always_ff @(posedge CLK) begin
    if (!RST || (state == IDLE && LD_START)) begin
      best_cnt <= '0;
      b1x <= SEVEN;
      b1y <= SEVEN;
      b2x <= SEVEN;
      b2y <= SEVEN;
    end else if (fin && fin_cnt > best_cnt) begin
      best_cnt <= fin_cnt;
      b1x <= c1x;
      b1y <= c1y;
      b2x <= c2x;
      b2y <= c2y;
    end
  end
  assign BEST_CNT = best_cnt;
  assign BEST_C1X = b1x;
  assign BEST_C1Y = b1y;
  assign BEST_C2X = b2x;
  assign BEST_C2Y = b2y;
`else
  assign BEST_CNT = '0;
  assign BEST_C1X = SEVEN;
  assign BEST_C1Y = SEVEN;
  assign BEST_C2X = SEVEN;
  assign BEST_C2Y = SEVEN;
`endif
endmodule

// File: tb/tb_laser_eval_ctrl.sv
// tb_laser_eval_ctrl: directed bench for laser_eval_ctrl with a result scoreboard queue.
module tb_laser_eval_ctrl;
  localparam int NPTS = 40;
  logic CLK = 1'b0, RST = 1'b0, LD_START = 1'b0, LD_VALID = 1'b0, REQ_VALID = 1'b0, RES_READY = 1'b0;
  logic [3:0] LD_X = '0, LD_Y = '0, REQ_C1X = '0, REQ_C1Y = '0, REQ_C2X = '0, REQ_C2Y = '0;
  logic LOADED, REQ_READY, RES_VALID;
  logic [5:0] RES_CNT, BEST_CNT;
  logic [3:0] BEST_C1X, BEST_C1Y, BEST_C2X, BEST_C2Y;
  int n_chk = 0, n_fail = 0;
  int px [NPTS];
  int py [NPTS];
  int exp_q [$];
  int bst = 0;
  int bc [4] = '{7, 7, 7, 7};

  always #5 CLK = ~CLK;

  laser_eval_ctrl dut (
    .CLK(CLK), .RST(RST), .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_X(LD_X), .LD_Y(LD_Y),
    .LOADED(LOADED), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_C1X(REQ_C1X), .REQ_C1Y(REQ_C1Y), .REQ_C2X(REQ_C2X), .REQ_C2Y(REQ_C2Y),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_CNT(RES_CNT), .BEST_CNT(BEST_CNT),
    .BEST_C1X(BEST_C1X), .BEST_C1Y(BEST_C1Y), .BEST_C2X(BEST_C2X), .BEST_C2Y(BEST_C2Y)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int c1x, c1y, c2x, c2y);
    int n = 0;
    for (int i = 0; i < NPTS; i++)
      if ((c1x - px[i]) * (c1x - px[i]) + (c1y - py[i]) * (c1y - py[i]) <= 16 ||
          (c2x - px[i]) * (c2x - px[i]) + (c2y - py[i]) * (c2y - py[i]) <= 16) n++;
    return n;
  endfunction

  task automatic check_best;
`ifdef LASER_BEST_TRACK_EN
    chk("best_cnt", BEST_CNT, bst);
    chk("best_c1x", BEST_C1X, bc[0]);
    chk("best_c1y", BEST_C1Y, bc[1]);
    chk("best_c2x", BEST_C2X, bc[2]);
    chk("best_c2y", BEST_C2Y, bc[3]);
`else
    chk("best_cnt", BEST_CNT, 0);
    chk("best_c1x", BEST_C1X, 7);
    chk("best_c2y", BEST_C2Y, 7);
`endif
  endtask

  task automatic load_pts;
    LD_START = 1'b1;
    tick;
    LD_START = 1'b0;
    chk("ld_clear", LOADED, 0);
    for (int i = 0; i < NPTS; i++) begin
      LD_VALID = 1'b1;
      LD_X = 4'(px[i]);
      LD_Y = 4'(py[i]);
      tick;
    end
    LD_VALID = 1'b0;
    chk("loaded", LOADED, 1);
    bst = 0;
    bc = '{7, 7, 7, 7};
  endtask

  task automatic run_req(input int c1x, c1y, c2x, c2y, input int hold, input bit disturb);
    int lat, e, w;
    w = 0;
    while (!REQ_READY && w < 20) begin
      tick;
      w++;
    end
    chk("req_ready", REQ_READY, 1);
    REQ_C1X = 4'(c1x);
    REQ_C1Y = 4'(c1y);
    REQ_C2X = 4'(c2x);
    REQ_C2Y = 4'(c2y);
    REQ_VALID = 1'b1;
    exp_q.push_back(model(c1x, c1y, c2x, c2y));
    tick;
    REQ_VALID = 1'b0;
    REQ_C1X = 4'd9;
    REQ_C1Y = 4'd9;
    REQ_C2X = 4'd9;
    REQ_C2Y = 4'd9;
    lat = 0;
    while (!RES_VALID && lat < 100) begin
      LD_START = disturb && lat == 5;
      LD_VALID = disturb && lat == 5;
      LD_X = 4'd15;
      LD_Y = 4'd15;
      tick;
      lat++;
    end
    LD_START = 1'b0;
    LD_VALID = 1'b0;
    chk("latency", lat, 41);
    e = -1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("res_cnt", RES_CNT, e);
    chk("loaded_kept", LOADED, 1);
    if (e > bst) begin
      bst = e;
      bc = '{c1x, c1y, c2x, c2y};
    end
    check_best;
    for (int i = 0; i < hold; i++) begin
      REQ_VALID = 1'b1;
      tick;
      chk("hold_valid", RES_VALID, 1);
      chk("hold_cnt", RES_CNT, e);
      chk("hold_req_ready", REQ_READY, 0);
    end
    REQ_VALID = 1'b0;
    RES_READY = 1'b1;
    tick;
    RES_READY = 1'b0;
    chk("res_drop", RES_VALID, 0);
    chk("req_ready_back", REQ_READY, 1);
    chk("cnt_keep", RES_CNT, e);
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_loaded", LOADED, 0);
    chk("rst_req_ready", REQ_READY, 0);
    chk("rst_res_valid", RES_VALID, 0);
    chk("rst_res_cnt", RES_CNT, 0);
    check_best;
    RST = 1'b1;
    tick;
    // all points at origin; full coverage, then far corner with no wrap
    for (int i = 0; i < NPTS; i++) begin px[i] = 0; py[i] = 0; end
    load_pts;
    LD_VALID = 1'b1;
    LD_X = 4'd15;
    LD_Y = 4'd15;
    tick;
    LD_VALID = 1'b0;
    run_req(0, 0, 0, 0, 0, 0);
    run_req(15, 15, 15, 15, 0, 0);
    // radius boundary points plus a held response
    for (int i = 0; i < NPTS; i++) begin px[i] = 15; py[i] = 0; end
    px[0] = 4; py[0] = 0;
    px[1] = 0; py[1] = 4;
    px[2] = 3; py[2] = 3;
    px[3] = 5; py[3] = 0;
    load_pts;
    run_req(0, 0, 15, 15, 10, 0);
    // overlap counted once; load attempt during evaluation ignored
    for (int i = 0; i < NPTS; i++) begin px[i] = 0; py[i] = 15; end
    px[0] = 7; py[0] = 7;
    load_pts;
    run_req(7, 7, 7, 7, 0, 1);
    // best tracking sequence 12, 30, 30, 25
    for (int i = 0; i < NPTS; i++) begin
      px[i] = i < 12 ? 2 : i < 30 ? 12 : i < 37 ? 7 : 0;
      py[i] = i < 12 ? 2 : i < 30 ? 12 : i < 37 ? 0 : 15;
    end
    load_pts;
    run_req(2, 2, 15, 15, 0, 0);
    run_req(2, 2, 12, 12, 0, 0);
    run_req(12, 12, 2, 2, 0, 0);
    run_req(12, 12, 7, 0, 0, 0);
    // reset in the middle of an evaluation
    REQ_C1X = 4'd0;
    REQ_C1Y = 4'd0;
    REQ_C2X = 4'd0;
    REQ_C2Y = 4'd0;
    REQ_VALID = 1'b1;
    tick;
    REQ_VALID = 1'b0;
    repeat (20) tick;
    RST = 1'b0;
    tick;
    RST = 1'b1;
    bst = 0;
    bc = '{7, 7, 7, 7};
    chk("mid_rst_res_valid", RES_VALID, 0);
    chk("mid_rst_loaded", LOADED, 0);
    chk("mid_rst_req_ready", REQ_READY, 0);
    chk("mid_rst_res_cnt", RES_CNT, 0);
    check_best;
    repeat (50) tick;
    chk("mid_rst_no_result", RES_VALID, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
